// File: rtl/en_pulse_pkg.sv
// Shared types and limits for the enable-pulse generator and its helpers.
package en_pulse_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PRESS_DB   = 3'd1,
        HELD       = 3'd2,
        REPEAT     = 3'd3,
        RELEASE_DB = 3'd4
    } state_t;

    localparam int MIN_SYNC_STAGES = 2;
    localparam int MIN_COUNT       = 2;

    // Largest of three counts; sizes the shared debounce/repeat counters.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchroniser for a single asynchronous bit, cleared by reset.
module bit_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    // Shift the raw bit through the flop chain; newest sample enters at bit 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/en_pulse_gen.sv
// Push-button conditioner: synchronises, debounces press/release and emits
// one single-cycle enable per accepted press, with optional auto-repeat.
module en_pulse_gen
    import en_pulse_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    input  logic repeat_en,
    output logic en_pulse,
    output logic btn_level
);

    localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD));
    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t DB_LAST = cnt_t'(DEBOUNCE_CYCLES - 1);
    localparam cnt_t RD_LAST = cnt_t'(REPEAT_DELAY - 1);
    localparam cnt_t RP_LAST = cnt_t'(REPEAT_PERIOD - 1);

    if (SYNC_STAGES < MIN_SYNC_STAGES || DEBOUNCE_CYCLES < MIN_COUNT ||
        REPEAT_DELAY < MIN_COUNT || REPEAT_PERIOD < MIN_COUNT) begin : g_bad_param
        $error("en_pulse_gen: parameter below its minimum");
    end

    logic   s;
    state_t state, state_nx;
    cnt_t   dcnt, dcnt_nx;
    cnt_t   rcnt, rcnt_nx;
    logic   pulse_nx;
    logic   level_nx;

    bit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_raw),
        .q   (s)
    );

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            dcnt  <= '0;
            rcnt  <= '0;
        end else begin
            state <= state_nx;
            dcnt  <= dcnt_nx;
            rcnt  <= rcnt_nx;
        end
    end

    // Next-state and counter update; a low on s always wins over a repeat expiry.
    always_comb begin
        state_nx = state;
        dcnt_nx  = dcnt;
        rcnt_nx  = rcnt;
        unique case (state)
            IDLE: begin
                if (s) state_nx = PRESS_DB;
            end
            PRESS_DB: begin
                if (!s)                 state_nx = IDLE;
                else if (dcnt == DB_LAST) state_nx = HELD;
                else                    dcnt_nx  = dcnt + cnt_t'(1);
            end
            HELD: begin
                if (!s)                 state_nx = RELEASE_DB;
                else if (!repeat_en)    rcnt_nx  = '0;
                else if (rcnt == RD_LAST) state_nx = REPEAT;
                else                    rcnt_nx  = rcnt + cnt_t'(1);
            end
            REPEAT: begin
                if (!s)                 state_nx = RELEASE_DB;
                else if (!repeat_en)    state_nx = HELD;
                else if (rcnt == RP_LAST) rcnt_nx = '0;
                else                    rcnt_nx  = rcnt + cnt_t'(1);
            end
            RELEASE_DB: begin
                if (s)                  state_nx = HELD;
                else if (dcnt == DB_LAST) state_nx = IDLE;
                else                    dcnt_nx  = dcnt + cnt_t'(1);
            end
            default: state_nx = IDLE;
        endcase
        // Both counters restart from zero whenever a state is entered.
        if (state_nx != state) begin
            dcnt_nx = '0;
            rcnt_nx = '0;
        end
    end

    // Output decode: pulse on press acceptance or repeat expiry, level tracks pressed states.
    always_comb begin
        pulse_nx = 1'b0;
        if (s) begin
            unique case (state)
                PRESS_DB: pulse_nx = (dcnt == DB_LAST);
                HELD:     pulse_nx = repeat_en && (rcnt == RD_LAST);
                REPEAT:   pulse_nx = repeat_en && (rcnt == RP_LAST);
                default:  pulse_nx = 1'b0;
            endcase
        end
        level_nx = (state_nx == HELD) || (state_nx == REPEAT) || (state_nx == RELEASE_DB);
    end

    // Registered outputs; reset drops any pulse due on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_pulse  <= 1'b0;
            btn_level <= 1'b0;
        end else begin
            en_pulse  <= pulse_nx;
            btn_level <= level_nx;
        end
    end

endmodule

// File: tb/tb_en_pulse_gen.sv
// Self-checking bench for en_pulse_gen: directed scenarios plus random stimulus
// compared against a run-length based behavioural model.
module tb_en_pulse_gen;

    localparam int SYNC = 2;
    localparam int DB   = 4;
    localparam int RD   = 8;
    localparam int RP   = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_raw = 1'b0;
    logic repeat_en = 1'b0;
    logic en_pulse;
    logic btn_level;

    always #5 clk = ~clk;

    en_pulse_gen #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .repeat_en (repeat_en),
        .en_pulse  (en_pulse),
        .btn_level (btn_level)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model: raw history delay line, then run-length rules.
    logic hist [SYNC];
    int   ones_run, zeros_run, ticks, limit;
    bit   pressed, releasing;
    bit   m_pulse, m_level;

    task automatic model_edge(input logic raw, input logic ren, input logic r);
        logic s;
        if (r) begin
            for (int i = 0; i < SYNC; i++) hist[i] = 1'b0;
            ones_run = 0; zeros_run = 0; ticks = 0; limit = RD;
            pressed = 0; releasing = 0; m_pulse = 0; m_level = 0;
            return;
        end
        s = hist[SYNC-1];
        for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = raw;
        m_pulse = 0;
        if (!pressed) begin
            ones_run = s ? ones_run + 1 : 0;
            if (ones_run == DB + 1) begin
                pressed = 1; m_level = 1; m_pulse = 1;
                releasing = 0; zeros_run = 0; ticks = 0; limit = RD; ones_run = 0;
            end
        end else if (releasing) begin
            if (s) begin
                releasing = 0; zeros_run = 0; ticks = 0; limit = RD;
            end else begin
                zeros_run++;
                if (zeros_run == DB + 1) begin
                    pressed = 0; releasing = 0; m_level = 0; ones_run = 0;
                end
            end
        end else begin
            if (!s) begin
                releasing = 1; zeros_run = 1;
            end else if (!ren) begin
                ticks = 0; limit = RD;
            end else begin
                ticks++;
                if (ticks == limit) begin
                    m_pulse = 1; ticks = 0; limit = RP;
                end
            end
        end
    endtask

    int       edge_n;
    int       pulse_edges[$];
    logic [3:0] cnt4;
    logic     prev_pulse;

    task automatic step(input logic raw, input logic ren, input logic r);
        @(negedge clk);
        btn_raw = raw; repeat_en = ren; rst = r;
        @(posedge clk);
        model_edge(raw, ren, r);
        #1;
        chk("en_pulse", {31'b0, en_pulse}, {31'b0, m_pulse});
        chk("btn_level", {31'b0, btn_level}, {31'b0, m_level});
        chk("no_adjacent", {31'b0, en_pulse & prev_pulse}, 32'd0);
        if (en_pulse === 1'b1) begin
            pulse_edges.push_back(edge_n);
            cnt4 = cnt4 + 4'd1;
        end
        prev_pulse = en_pulse;
        edge_n++;
    endtask

    task automatic new_scenario();
        edge_n = 0;
        pulse_edges.delete();
    endtask

    function automatic int first_edge();
        return (pulse_edges.size() > 0) ? pulse_edges[0] : -1;
    endfunction

    task automatic press_release(input int hi, input int lo);
        for (int i = 0; i < hi; i++) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < lo; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    int run_left;
    logic rraw, rren, rrst;
    int exp_rep [7] = '{6, 14, 17, 20, 23, 26, 29};

    initial begin
        cnt4 = 4'd0;
        prev_pulse = 1'b0;
        edge_n = 0;
        model_edge(1'b0, 1'b0, 1'b1);

        // Reset state
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
        chk("rst_en_pulse", {31'b0, en_pulse}, 32'd0);
        chk("rst_btn_level", {31'b0, btn_level}, 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);

        // Clean press, no repeat
        new_scenario();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (edge_n == 7) chk("clean_level_at6", {31'b0, btn_level}, 32'd1);
            if (edge_n == 6) chk("clean_level_at5", {31'b0, btn_level}, 32'd0);
        end
        chk("clean_npulse", pulse_edges.size(), 32'd1);
        chk("clean_edge", first_edge(), 32'd6);
        new_scenario();
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (edge_n == 6) chk("rel_level_at5", {31'b0, btn_level}, 32'd1);
            if (edge_n == 7) chk("rel_level_at6", {31'b0, btn_level}, 32'd0);
        end

        // Bounce on press: high 2, low 1, then steady high (final rise at edge 3)
        new_scenario();
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 1'b0);
        chk("bounce_npulse", pulse_edges.size(), 32'd1);
        chk("bounce_edge", first_edge(), 32'd9);
        press_release(0, 10);

        // Auto-repeat while held for 30 cycles
        new_scenario();
        for (int i = 0; i < 30; i++) step(1'b1, 1'b1, 1'b0);
        chk("rep_npulse", pulse_edges.size(), 32'd7);
        for (int i = 0; i < 7; i++) begin
            chk("rep_edge", (i < pulse_edges.size()) ? pulse_edges[i] : -1, exp_rep[i]);
        end
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0);

        // Release bounce during HELD, then auto-repeat resumes from a fresh delay
        press_release(10, 0);
        new_scenario();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
        chk("relb_npulse", pulse_edges.size(), 32'd0);
        chk("relb_level", {31'b0, btn_level}, 32'd1);
        new_scenario();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0);
        chk("relb_repeat_edge", first_edge(), 32'd7);
        press_release(0, 10);

        // Reset mid-debounce, then a fresh press needs the full latency
        new_scenario();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        chk("midrst_en_pulse", {31'b0, en_pulse}, 32'd0);
        chk("midrst_btn_level", {31'b0, btn_level}, 32'd0);
        new_scenario();
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0);
        chk("midrst_edge", first_edge(), 32'd6);
        chk("midrst_npulse", pulse_edges.size(), 32'd1);
        press_release(0, 10);

        // Downstream 4-bit counter integration
        cnt4 = 4'd0;
        for (int i = 0; i < 5; i++) press_release(10, 10);
        chk("counter_5", {28'b0, cnt4}, 32'd5);
        for (int i = 0; i < 16; i++) press_release(10, 10);
        chk("counter_wrap", {28'b0, cnt4}, 32'd5);

        // Random stimulus against the model
        rraw = 1'b0;
        rren = 1'b0;
        run_left = 0;
        for (int i = 0; i < 4000; i++) begin
            if (run_left == 0) begin
                rraw = ~rraw;
                run_left = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 45)
                                                        : $urandom_range(1, 8);
            end
            run_left--;
            if ($urandom_range(0, 40) == 0) rren = ~rren;
            rrst = ($urandom_range(0, 600) == 0);
            step(rraw, rren, rrst);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/en_pulse_gen.md
# en_pulse_gen

Conditions a raw, asynchronous push-button or strobe input into clean single-cycle enable pulses for the downstream 4-bit event counter. Each pulse advances that counter by exactly one. The block synchronises the input, debounces press and release, and emits one pulse per accepted press. It optionally auto-repeats while the input is held. It sits directly upstream of the counter and drives the counter's enable.

## Interface
- SYNC_STAGES, 2: synchroniser flop depth, minimum 2.
- DEBOUNCE_CYCLES, 16: cycles the input must be stable to accept a press or release, minimum 2.
- REPEAT_DELAY, 64: held cycles before the first auto-repeat pulse, minimum 2.
- REPEAT_PERIOD, 16: cycles between subsequent auto-repeat pulses, minimum 2.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- btn_raw  in  1  asynchronous raw input; high means pressed.
- repeat_en  in  1  quasi-static; enables auto-repeat while held.
- en_pulse  out  1  registered single-cycle enable to the counter.
- btn_level  out  1  registered debounced level.

## Operation
- btn_raw passes through a SYNC_STAGES flop chain, reset 0. Its output is s. Only s is used internally.
- dcnt (debounce) and rcnt (repeat) are unsigned counters. Width is $clog2 of the largest of the three count parameters. Neither counter ever wraps; both are reloaded to 0 on every state entry.
- FSM states and transitions:
  - IDLE: s=1 → PRESS_DB, dcnt=0.
  - PRESS_DB, on s=0: → IDLE, no pulse.
  - PRESS_DB, on s=1 with dcnt==DEBOUNCE_CYCLES-1: → HELD; btn_level←1; en_pulse←1; rcnt=0.
  - PRESS_DB, on s=1 otherwise: dcnt++.
  - HELD, on s=0: → RELEASE_DB, dcnt=0.
  - HELD, on repeat_en=0: rcnt held at 0.
  - HELD, on repeat_en=1: rcnt++. At rcnt==REPEAT_DELAY-1 → REPEAT; en_pulse←1; rcnt=0.
  - REPEAT, on s=0: → RELEASE_DB, dcnt=0.
  - REPEAT, on repeat_en=0: → HELD, rcnt=0, no pulse.
  - REPEAT, otherwise: rcnt++. At rcnt==REPEAT_PERIOD-1, en_pulse←1 and rcnt=0.
  - RELEASE_DB, on s=1: → HELD, rcnt=0, no pulse. The bounce is absorbed.
  - RELEASE_DB, on s=0 with dcnt==DEBOUNCE_CYCLES-1: → IDLE; btn_level←0.
  - RELEASE_DB, on s=0 otherwise: dcnt++.
- en_pulse is high for exactly one cycle per event and is never high on two consecutive cycles.
- Simultaneous events: s=0 takes priority over any repeat expiry on the same edge. The release wins and no pulse is emitted.

## Timing
- Reset values: en_pulse=0, btn_level=0, all sync flops=0, state=IDLE, dcnt=rcnt=0.
- rst asserted mid-operation, in any state, returns everything to reset values on that edge. A pulse scheduled for that edge is dropped.
- Press latency: take edge 0 as the first edge that samples btn_raw=1, with btn_raw stable afterwards. en_pulse is high in the cycle after edge SYNC_STAGES+DEBOUNCE_CYCLES. btn_level rises on the same edge.
- Release latency: btn_level falls after edge SYNC_STAGES+DEBOUNCE_CYCLES, counted from the first edge that samples btn_raw=0.
- First repeat pulse: REPEAT_DELAY edges after the press pulse. Following repeat pulses are spaced REPEAT_PERIOD edges apart.
- Any low glitch on s shorter than DEBOUNCE_CYCLES during PRESS_DB restarts acceptance from IDLE.

## Structure
- Shared package en_pulse_pkg:
  - typedef enum state_t {IDLE, PRESS_DB, HELD, REPEAT, RELEASE_DB}, 3-bit encoding.
  - Parameter range constants (MIN_SYNC_STAGES=2, MIN_COUNT=2).
- Sub-module bit_sync: parameterised SYNC_STAGES flop chain with synchronous reset. It is reused for other asynchronous inputs.
- All remaining logic stays in en_pulse_gen, as one FSM process plus registered outputs.

## Test plan
All scenarios use SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3.
- Clean press: btn_raw 0→1 held 20 cycles, repeat_en=0 → one en_pulse after edge 6; btn_level=1 from edge 6; no further pulses.
- Bounce on press: btn_raw high for 2 cycles, low for 1, then high steadily → exactly one pulse, 6 edges after the final rise.
- Auto-repeat: repeat_en=1, hold for 30 cycles → pulses at edges 6, 14, 17, 20, 23, 26 (plus further ones while still held); consecutive pulses are never adjacent.
- Release bounce: during HELD, btn_raw low for 3 cycles, then high → no pulse; btn_level stays 1; state returns to HELD.
- Reset mid-debounce: assert rst at edge 4 of a press → outputs are 0 from that edge; after rst deasserts, a fresh press needs the full 6-edge latency.
- Counter integration: 5 clean presses into the downstream counter → the counter reads 4'd5; after 16 more presses it wraps to 4'd5 again.
